// File: rtl/wq_pkg.sv
// Shared types and sizes for the store write queue.
// Queue entries pack {addr, data} with the address in the upper half.
package wq_pkg;

  localparam int WQ_DEPTH = 8;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int PTR_W    = 3;
  localparam int ENTRY_W  = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } wq_state_e;

endpackage

// File: rtl/write_queue_fifo.sv
// 8-entry store FIFO with a registered head read.
// Caller guarantees no push when full and no pop when empty.
module write_queue_fifo
  import wq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_rd_en,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [WQ_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   w_rptr_nxt;
  logic [ENTRY_W-1:0] r_rdata;

  // Read ahead from the post-pop pointer so the head is fresh
  // in the cycle right after a pop.
  assign w_rptr_nxt = i_rd_en ? r_rptr + PTR_W'(1) : r_rptr;
  assign o_rdata    = r_rdata;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + PTR_W'(1);
      r_rptr  <= w_rptr_nxt;
      r_rdata <= r_mem[w_rptr_nxt];
    end
  end

endmodule

// File: rtl/write_queue_ctrl.sv
// Store write queue with in-order drain and load hazard ordering.
// Loads wait for older same-address stores; no data forwarding.
module write_queue_ctrl
  import wq_pkg::*;
#(
  parameter int DRAIN_THRESH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_stall,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_done,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        wq_count,
  output logic              wq_empty
);

  localparam logic [3:0] THR  = 4'(DRAIN_THRESH);
  localparam logic [3:0] FULL = 4'(WQ_DEPTH);

  wq_state_e r_state;
  wq_state_e w_next;

  logic [3:0]         r_count;
  logic               r_push_d1;
  logic               r_push_d2;
  logic [ADDR_W-1:0]  r_sh_addr [WQ_DEPTH];
  logic [WQ_DEPTH-1:0] r_sh_vld;
  logic [PTR_W-1:0]   r_sh_head;
  logic [PTR_W-1:0]   r_sh_tail;

  logic               r_mem_req;
  logic               r_mem_wen;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_ld_fin;
  logic               w_hazard;
  logic               w_head_ok;
  logic [3:0]         w_recent;
  logic [ENTRY_W-1:0] w_head;

  assign w_full   = (r_count == FULL);
  assign w_push   = st_req && !w_full;
  assign w_pop    = (r_state == DRAIN) && mem_ready;
  assign w_ld_fin = (r_state == LOAD) && mem_ready;

  // Entries pushed in the last two cycles are not yet visible
  // at the FIFO read port.
  assign w_recent  = {3'b0, r_push_d1} + {3'b0, r_push_d2};
  assign w_head_ok = (r_count > w_recent);

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (r_sh_vld[i] && (r_sh_addr[i] == ld_addr)) w_hazard = 1'b1;
    end
  end

  write_queue_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr_en (w_push),
    .i_wdata ({st_addr, st_data}),
    .i_rd_en (w_pop),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_head_ok && (r_count >= THR))     w_next = DRAIN;
        else if (ld_req && !w_hazard)          w_next = LOAD;
        else if (ld_req && w_head_ok)          w_next = DRAIN;
        else if (!ld_req && w_head_ok)         w_next = DRAIN;
      end
      DRAIN:   if (mem_ready) w_next = IDLE;
      LOAD:    if (mem_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == IDLE && w_next == DRAIN) begin
      r_mem_req   <= 1'b1;
      r_mem_wen   <= 1'b1;
      r_mem_addr  <= w_head[ENTRY_W-1:DATA_W];
      r_mem_wdata <= w_head[DATA_W-1:0];
    end else if (r_state == IDLE && w_next == LOAD) begin
      r_mem_req   <= 1'b1;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= ld_addr;
    end else if (w_pop || w_ld_fin) begin
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_push_d1 <= 1'b0;
      r_push_d2 <= 1'b0;
    end else begin
      r_push_d1 <= w_push;
      r_push_d2 <= r_push_d1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_vld  <= '0;
      r_sh_head <= '0;
      r_sh_tail <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) r_sh_addr[i] <= '0;
    end else begin
      if (w_push) begin
        r_sh_addr[r_sh_tail] <= st_addr;
        r_sh_vld[r_sh_tail]  <= 1'b1;
        r_sh_tail            <= r_sh_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_sh_vld[r_sh_head] <= 1'b0;
        r_sh_head           <= r_sh_head + PTR_W'(1);
      end
    end
  end

  assign st_stall  = w_full;
  assign wq_count  = r_count;
  assign wq_empty  = (r_count == 4'd0);
  assign mem_req   = r_mem_req;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ld_done   = w_ld_fin;
  assign ld_data   = w_ld_fin ? mem_rdata : '0;

endmodule
